// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

   localparam int STALL_W = 16;

   // Index width that never collapses to zero bits.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle of the write arbiter; slave = arbiter, master = producers + FIFO.
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_SIZE = 8
);
   localparam int ID_W = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*DATA_SIZE-1:0] req_data;
   logic [NUM_REQ-1:0]           req_ready;
   logic                         wr_full;
   logic                         wr_en;
   logic [DATA_SIZE-1:0]         wr_data;
   logic                         gnt_valid;
   logic [ID_W-1:0]              gnt_id;
   logic [STALL_W-1:0]           stall_cnt;

   modport slave (
      input  req_valid, req_data, wr_full,
      output req_ready, wr_en, wr_data, gnt_valid, gnt_id, stall_cnt
   );

   modport master (
      output req_valid, req_data, wr_full,
      input  req_ready, wr_en, wr_data, gnt_valid, gnt_id, stall_cnt
   );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating priority pick: first set bit of i_req at or after i_start, wrapping.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N = 4,
   localparam int W = id_width(N)
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_start,
   output logic         o_found,
   output logic [W-1:0] o_idx
);
   int w_j;

   // Scan from the far end so the candidate closest to i_start is written last.
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_j     = 0;
      for (int k = N - 1; k >= 0; k--) begin
         w_j = (int'(i_start) + k) % N;
         if (i_req[w_j]) begin
            o_found = 1'b1;
            o_idx   = W'(w_j);
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing the FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int DATA_SIZE = 8,
   parameter int NUM_REQ   = 4,
   parameter int BURST_MAX = 4
) (
   input  logic               clk,
   input  logic               rst,
   fifo_wr_arbiter_if.slave   bus
);
   localparam int ID_W  = id_width(NUM_REQ);
   localparam int CNT_W = id_width(BURST_MAX);

   arb_state_t         r_state,     w_state_nxt;
   logic [ID_W-1:0]    r_owner,     w_owner_nxt;
   logic [ID_W-1:0]    r_last_gnt,  w_last_nxt;
   logic [CNT_W-1:0]   r_burst_cnt, w_burst_nxt;
   logic [STALL_W-1:0] r_stall_cnt, w_stall_nxt;

   logic                 w_grant;
   logic                 w_owner_valid;
   logic                 w_xfer;
   logic                 w_release;
   logic [NUM_REQ-1:0]   w_owner_oh;
   logic [NUM_REQ-1:0]   w_masked_req;
   logic [NUM_REQ-1:0]   w_pick_req;
   logic [ID_W-1:0]      w_pick_start;
   logic                 w_found;
   logic [ID_W-1:0]      w_pick_idx;
   logic [DATA_SIZE-1:0] w_owner_data;

   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] x);
      return (int'(x) == NUM_REQ - 1) ? '0 : x + 1'b1;
   endfunction

   always_comb begin
      w_owner_oh          = '0;
      w_owner_oh[r_owner] = 1'b1;
   end

   assign w_grant       = (r_state == ARB_GRANT);
   assign w_owner_valid = bus.req_valid[r_owner];
   assign w_xfer        = w_grant & w_owner_valid & ~bus.wr_full;
   assign w_release     = w_grant &
                          ((w_xfer & (r_burst_cnt == CNT_W'(BURST_MAX - 1))) | ~w_owner_valid);
   assign w_owner_data  = bus.req_data[int'(r_owner)*DATA_SIZE +: DATA_SIZE];

   // A finished owner only re-wins when nobody else is waiting.
   assign w_masked_req = bus.req_valid & ~w_owner_oh;
   assign w_pick_req   = (w_xfer && (|w_masked_req)) ? w_masked_req : bus.req_valid;
   assign w_pick_start = wrap_inc(w_grant ? r_owner : r_last_gnt);

   rr_pick #(.N(NUM_REQ)) u_pick (
      .i_req   (w_pick_req),
      .i_start (w_pick_start),
      .o_found (w_found),
      .o_idx   (w_pick_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ARB_IDLE;
         r_owner     <= '0;
         r_last_gnt  <= ID_W'(NUM_REQ - 1);
         r_burst_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_owner     <= w_owner_nxt;
         r_last_gnt  <= w_last_nxt;
         r_burst_cnt <= w_burst_nxt;
         r_stall_cnt <= w_stall_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last_gnt;
      w_burst_nxt = r_burst_cnt;
      w_stall_nxt = r_stall_cnt;

      case (r_state)
         ARB_IDLE: begin
            if (w_found) begin
               w_owner_nxt = w_pick_idx;
               w_state_nxt = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            if (w_release) begin
               w_last_nxt  = r_owner;
               w_burst_nxt = '0;
               if (w_found) w_owner_nxt = w_pick_idx;
               else         w_state_nxt = ARB_IDLE;
            end else if (w_xfer) begin
               w_burst_nxt = r_burst_cnt + 1'b1;
            end
            if (w_owner_valid && bus.wr_full && (r_stall_cnt != {STALL_W{1'b1}}))
               w_stall_nxt = r_stall_cnt + 1'b1;
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = '0;
      if (w_grant) bus.req_ready[r_owner] = ~bus.wr_full;
   end

   assign bus.wr_en     = w_xfer;
   assign bus.wr_data   = w_xfer ? w_owner_data : '0;
   assign bus.gnt_valid = w_grant;
   assign bus.gnt_id    = r_owner;
   assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: fixed vectors, directed corner sequences, random traffic vs. a reference model.
module tb_fifo_wr_arbiter;
   localparam int NREQ  = 4;
   localparam int DW    = 8;
   localparam int BURST = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.NUM_REQ(NREQ), .DATA_SIZE(DW)) bus ();

   fifo_wr_arbiter #(.DATA_SIZE(DW), .NUM_REQ(NREQ), .BURST_MAX(BURST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: who holds the port and how many words it has moved in this grant.
   bit m_busy;
   int m_owner, m_last, m_words, m_stall;

   // Outputs captured in the last tick, for directed checks.
   logic       s_en, s_gv;
   logic [7:0] s_data;
   logic [1:0] s_id;
   logic [3:0] s_rdy;
   logic [15:0] s_stall;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_words = 0; m_stall = 0;
   endtask

   // Next valid requester strictly after 'after', wrapping, 'after' itself considered last.
   function automatic int next_valid(input logic [3:0] v, input int after);
      for (int k = 1; k <= NREQ; k++)
         if (v[(after + k) % NREQ]) return (after + k) % NREQ;
      return -1;
   endfunction

   task automatic tick(input logic [3:0] v, input logic [31:0] d, input logic f, input logic r);
      logic [3:0] e_rdy;
      logic       e_en;
      logic [7:0] e_data;
      logic [1:0] a_id, e_id;
      int p;
      bit give_up;
      bus.req_valid = v; bus.req_data = d; bus.wr_full = f; rst = r;
      #4;
      e_en   = m_busy && v[m_owner] && !f;
      e_rdy  = (m_busy && !f) ? (4'b0001 << m_owner) : 4'b0000;
      e_data = e_en ? d[m_owner*8 +: 8] : 8'h00;
      e_id   = m_busy ? 2'(m_owner) : 2'd0;
      a_id   = m_busy ? bus.gnt_id : 2'd0;
      check("model", {bus.req_ready, bus.wr_en, bus.wr_data, bus.gnt_valid, a_id, bus.stall_cnt},
                     {e_rdy, e_en, e_data, m_busy, e_id, 16'(m_stall)});
      s_en = bus.wr_en; s_gv = bus.gnt_valid; s_data = bus.wr_data;
      s_id = bus.gnt_id; s_rdy = bus.req_ready; s_stall = bus.stall_cnt;
      if (r) model_reset();
      else if (!m_busy) begin
         p = next_valid(v, m_last);
         if (p >= 0) begin m_busy = 1; m_owner = p; m_words = 0; end
      end else begin
         if (v[m_owner] && f && m_stall < 65535) m_stall++;
         give_up = !v[m_owner];
         if (e_en) begin
            m_words++;
            if (m_words == BURST) give_up = 1;
         end
         if (give_up) begin
            m_last = m_owner; m_words = 0;
            p = next_valid(v, m_owner);
            if (p >= 0) m_owner = p; else m_busy = 0;
         end
      end
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [3:0] v;  logic [7:0] d1; logic f;
      logic en; logic [7:0] wd; logic gv; logic [1:0] id; logic [3:0] rdy;
   } vec_t;

   vec_t tbl[9];

   initial begin
      rst = 1'b1; bus.req_valid = '0; bus.req_data = '0; bus.wr_full = 1'b0;
      model_reset();
      @(posedge clk); #1;

      for (int i = 0; i < 3; i++) begin
         tick(4'b0000, 32'h0, 1'b0, 1'b1);
         check("reset_idle", {s_en, s_gv, s_stall}, {1'b0, 1'b0, 16'h0});
      end

      // Lone requester 1: one arbitration cycle, burst of four, re-grant to itself, then drop.
      tbl[0] = '{4'b0010, 8'hA0, 0, 0, 8'h00, 0, 2'd0, 4'b0000};
      tbl[1] = '{4'b0010, 8'hA0, 0, 1, 8'hA0, 1, 2'd1, 4'b0010};
      tbl[2] = '{4'b0010, 8'hA1, 0, 1, 8'hA1, 1, 2'd1, 4'b0010};
      tbl[3] = '{4'b0010, 8'hA2, 0, 1, 8'hA2, 1, 2'd1, 4'b0010};
      tbl[4] = '{4'b0010, 8'hA3, 0, 1, 8'hA3, 1, 2'd1, 4'b0010};
      tbl[5] = '{4'b0010, 8'hA4, 0, 1, 8'hA4, 1, 2'd1, 4'b0010};
      tbl[6] = '{4'b0010, 8'hA5, 0, 1, 8'hA5, 1, 2'd1, 4'b0010};
      tbl[7] = '{4'b0000, 8'h00, 0, 0, 8'h00, 1, 2'd1, 4'b0010};
      tbl[8] = '{4'b0000, 8'h00, 0, 0, 8'h00, 0, 2'd0, 4'b0000};
      for (int i = 0; i < 9; i++) begin
         tick(tbl[i].v, {8'h33, 8'h22, tbl[i].d1, 8'h11}, tbl[i].f, 1'b0);
         check($sformatf("vec%0d", i),
               {s_en, s_data, s_gv, (s_gv ? s_id : 2'd0), s_rdy},
               {tbl[i].en, tbl[i].wd, tbl[i].gv, tbl[i].id, tbl[i].rdy});
      end

      // All four requesting: 4-word bursts rotate 0,1,2,3,0 with no idle write cycles.
      tick(4'b0000, 32'h0, 1'b0, 1'b1);
      tick(4'b1111, $urandom, 1'b0, 1'b0);
      check("rr_arb_cycle", {31'h0, s_en}, 64'h0);
      for (int k = 0; k < 17; k++) begin
         tick(4'b1111, $urandom, 1'b0, 1'b0);
         check($sformatf("rr_word%0d", k), {s_en, s_id}, {1'b1, 2'((k / 4) % 4)});
      end

      // Requester 2 stalled by full for five cycles mid-burst.
      tick(4'b0000, 32'h0, 1'b0, 1'b1);
      tick(4'b0100, $urandom, 1'b0, 1'b0);
      tick(4'b0100, $urandom, 1'b0, 1'b0);
      tick(4'b0100, $urandom, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         tick(4'b0100, $urandom, 1'b1, 1'b0);
         check("stall_hold", {s_en, s_rdy, s_id, s_gv}, {1'b0, 4'b0000, 2'd2, 1'b1});
      end
      tick(4'b0100, $urandom, 1'b0, 1'b0);
      check("stall_cnt", {s_en, s_stall}, {1'b1, 16'd5});
      tick(4'b0100, $urandom, 1'b0, 1'b0);
      check("stall_resume", {s_en, s_id}, {1'b1, 2'd2});

      // Requester 3 drops valid after two words; requester 0 takes over next cycle.
      tick(4'b0000, 32'h0, 1'b0, 1'b1);
      tick(4'b1000, $urandom, 1'b0, 1'b0);
      tick(4'b1001, $urandom, 1'b0, 1'b0);
      tick(4'b1001, $urandom, 1'b0, 1'b0);
      check("drop_word2", {s_en, s_id}, {1'b1, 2'd3});
      tick(4'b0001, $urandom, 1'b0, 1'b0);
      check("drop_forfeit", {s_en, s_id}, {1'b0, 2'd3});
      for (int k = 0; k < 4; k++) begin
         tick(4'b0001, $urandom, 1'b0, 1'b0);
         check("drop_new_owner", {s_en, s_id}, {1'b1, 2'd0});
      end

      // Reset in the middle of a burst by requester 1.
      tick(4'b0000, 32'h0, 1'b0, 1'b1);
      tick(4'b0010, $urandom, 1'b0, 1'b0);
      tick(4'b0011, $urandom, 1'b0, 1'b0);
      tick(4'b0011, $urandom, 1'b0, 1'b1);
      tick(4'b0011, $urandom, 1'b0, 1'b0);
      check("rst_mid_burst", {s_en, s_gv}, {1'b0, 1'b0});
      tick(4'b0011, $urandom, 1'b0, 1'b0);
      check("rst_first_owner", {s_en, s_gv, s_id}, {1'b1, 1'b1, 2'd0});

      // Random traffic against the model.
      for (int k = 0; k < 400; k++)
         tick(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 99) == 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
